// File: rtl/effect_queue.sv
// effect_queue: FIFO of sound-effect codes feeding the audio engine.
// Each queued code is issued as a 1-cycle pulse, and the next one only
// after the previous clip's fixed playback time has fully elapsed.
//
// Ports:
//   clk_in       system clock, all logic on posedge
//   rst_in       synchronous active-high reset
//   req_in       effect request (nonzero = push this cycle)
//   effect_out   code for exactly one cycle, else 0
//   busy_out     1 while a clip is playing
//   count_out    FIFO occupancy, 0..DEPTH
//   overflow_out 1-cycle pulse when a request is dropped (FIFO full)
//
// Optional feature: define EFFECT_QUEUE_COALESCE_EN to discard requests
// equal to the tail entry, or (empty FIFO) equal to the code playing.

module effect_queue #(
    parameter int DEPTH       = 4,
    parameter int CLIP_CYCLES = 22_152_568
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    input  logic [1:0]                 req_in,
    output logic [1:0]                 effect_out,
    output logic                       busy_out,
    output logic [$clog2(DEPTH):0]     count_out,
    output logic                       overflow_out
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(CLIP_CYCLES);

    typedef enum logic {IDLE, PLAYING} state_t;

    state_t          state;
    state_t          state_next;
    logic [TW-1:0]   timer;
    logic [TW-1:0]   timer_next;
    logic [1:0]      effect_next;
    logic [1:0]      mem [DEPTH];
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic [CW-1:0]   count;

    logic            req_valid;
    logic            discard;
    logic            pop;
    logic            push;
    logic            drop;
    logic            full;
    logic            timer_done;

    assign req_valid  = (req_in != 2'd0);
    assign full       = (count == CW'(DEPTH));
    assign timer_done = (timer == '0);

`ifdef EFFECT_QUEUE_COALESCE_EN
    logic [1:0]    playing;
    logic [AW-1:0] tail_ptr;

    assign tail_ptr = wr_ptr - 1'b1;

    // Duplicate of the newest pending code, or of the clip currently
    // sounding when nothing is pending, adds nothing audible.
    always_comb begin
        discard = 1'b0;
        if (req_valid) begin
            if (count != '0)
                discard = (req_in == mem[tail_ptr]);
            else if (state == PLAYING)
                discard = (req_in == playing);
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in)
            playing <= 2'd0;
        else if (pop)
            playing <= mem[rd_ptr];
    end
`else
    assign discard = 1'b0;
`endif

    // Pop uses the pre-edge count, so a push into an empty FIFO is never
    // bypassed straight to the output.
    assign pop  = (state == IDLE) && (count != '0);
    assign push = req_valid && !discard && (!full || pop);
    assign drop = req_valid && !discard && full && !pop;

    // State register
    always_ff @(posedge clk_in) begin
        if (rst_in)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (pop) state_next = PLAYING;
            PLAYING: if (timer_done) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output / datapath next values (registered below)
    always_comb begin
        effect_next = 2'd0;
        timer_next  = timer;
        unique case (state)
            IDLE: begin
                if (pop) begin
                    effect_next = mem[rd_ptr];
                    timer_next  = TW'(CLIP_CYCLES - 1);
                end
            end
            PLAYING: begin
                if (!timer_done)
                    timer_next = timer - 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            timer        <= '0;
            effect_out   <= 2'd0;
            busy_out     <= 1'b0;
            overflow_out <= 1'b0;
        end else begin
            timer        <= timer_next;
            effect_out   <= effect_next;
            busy_out     <= (state_next == PLAYING);
            overflow_out <= drop;
        end
    end

    // FIFO storage; contents need no reset, pointers define validity
    always_ff @(posedge clk_in) begin
        if (!rst_in && push)
            mem[wr_ptr] <= req_in;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign count_out = count;

endmodule
